// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: two-master round-robin bus arbiter with bounded lock hold
`ifndef XLEN
`define XLEN 32
`endif
module bus_master_arbiter #(
    parameter int XLEN = `XLEN,
    parameter int LOCK_MAX = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            m0_req_valid,
    input  logic [XLEN-1:0] m0_req_addr,
    input  logic [63:0]     m0_req_wdata,
    input  logic            m0_req_we,
    input  logic [2:0]      m0_req_size,
    input  logic            m0_req_lock,
    output logic            m0_req_ready,
    output logic [63:0]     m0_req_rdata,
    input  logic            m1_req_valid,
    input  logic [XLEN-1:0] m1_req_addr,
    input  logic [63:0]     m1_req_wdata,
    input  logic            m1_req_we,
    input  logic [2:0]      m1_req_size,
    input  logic            m1_req_lock,
    output logic            m1_req_ready,
    output logic [63:0]     m1_req_rdata,
    output logic            bus_req_valid,
    output logic [XLEN-1:0] bus_req_addr,
    output logic [63:0]     bus_req_wdata,
    output logic            bus_req_we,
    output logic [2:0]      bus_req_size,
    input  logic            bus_req_ready,
    input  logic [63:0]     bus_req_rdata,
    output logic [1:0]      grant,
    output logic            busy
);
    localparam int LW = $clog2(LOCK_MAX) + 1;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t state, next_state;
    logic last_grant;
    logic [LW-1:0] lock_cnt;
    logic sel0, sel1, lock_g, lock_ok, done;
    assign sel0 = state == GRANT0;
    assign sel1 = state == GRANT1;
    assign lock_g = sel0 ? m0_req_lock : sel1 && m1_req_lock;
    assign lock_ok = int'(lock_cnt) + 1 < LOCK_MAX;
    assign done = busy && bus_req_valid && bus_req_ready;
    // lock_cnt saturates at LOCK_MAX-1 while the holder keeps the bus with nobody waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            last_grant <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state <= next_state;
            if (done) last_grant <= sel1;
            lock_cnt <= (next_state != state || !busy || (done && !lock_g)) ? '0 :
                        (done && lock_ok) ? lock_cnt + 1'b1 : lock_cnt;
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (m0_req_valid && (!m1_req_valid || last_grant)) ? GRANT0 :
                                  m1_req_valid ? GRANT1 : IDLE;
            GRANT0:  next_state = !m0_req_valid ? IDLE :
                                  (!bus_req_ready || (m0_req_lock && lock_ok) || !m1_req_valid) ? GRANT0 : GRANT1;
            GRANT1:  next_state = !m1_req_valid ? IDLE :
                                  (!bus_req_ready || (m1_req_lock && lock_ok) || !m0_req_valid) ? GRANT1 : GRANT0;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        grant = {sel1, sel0};
        busy = state != IDLE;
        bus_req_valid = sel0 ? m0_req_valid : sel1 && m1_req_valid;
        bus_req_addr = sel0 ? m0_req_addr : sel1 ? m1_req_addr : '0;
        bus_req_wdata = sel0 ? m0_req_wdata : sel1 ? m1_req_wdata : '0;
        bus_req_we = sel0 ? m0_req_we : sel1 && m1_req_we;
        bus_req_size = sel0 ? m0_req_size : sel1 ? m1_req_size : '0;
        m0_req_ready = sel0 && bus_req_ready;
        m1_req_ready = sel1 && bus_req_ready;
        m0_req_rdata = sel0 ? bus_req_rdata : '0;
        m1_req_rdata = sel1 ? bus_req_rdata : '0;
    end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: directed stimulus with a transfer scoreboard for bus_master_arbiter
module tb_bus_master_arbiter;
    localparam int XLEN = 32;
    localparam logic [63:0] RD = 64'hA5A5_0000_1234_5678;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic m0_req_valid, m0_req_we, m0_req_lock, m0_req_ready;
    logic [XLEN-1:0] m0_req_addr;
    logic [63:0] m0_req_wdata, m0_req_rdata;
    logic [2:0] m0_req_size;
    logic m1_req_valid, m1_req_we, m1_req_lock, m1_req_ready;
    logic [XLEN-1:0] m1_req_addr;
    logic [63:0] m1_req_wdata, m1_req_rdata;
    logic [2:0] m1_req_size;
    logic bus_req_valid, bus_req_we, bus_req_ready, busy;
    logic [XLEN-1:0] bus_req_addr;
    logic [63:0] bus_req_wdata, bus_req_rdata;
    logic [2:0] bus_req_size;
    logic [1:0] grant;
    typedef struct packed {
        logic [1:0]  g;
        logic [1:0]  rdy;
        logic [31:0] a;
        logic [63:0] d;
        logic        we;
        logic [2:0]  sz;
        logic [63:0] r0;
        logic [63:0] r1;
    } xfer_t;
    xfer_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_master_arbiter #(.XLEN(XLEN), .LOCK_MAX(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_req_we(m0_req_we), .m0_req_size(m0_req_size), .m0_req_lock(m0_req_lock),
        .m0_req_ready(m0_req_ready), .m0_req_rdata(m0_req_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_req_we(m1_req_we), .m1_req_size(m1_req_size), .m1_req_lock(m1_req_lock),
        .m1_req_ready(m1_req_ready), .m1_req_rdata(m1_req_rdata),
        .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
        .bus_req_we(bus_req_we), .bus_req_size(bus_req_size), .bus_req_ready(bus_req_ready),
        .bus_req_rdata(bus_req_rdata), .grant(grant), .busy(busy)
    );

    function automatic xfer_t mk(input logic [1:0] g, input logic [31:0] a, input logic [63:0] d,
                                 input logic we, input logic [2:0] sz);
        xfer_t x;
        x.g = g;
        x.rdy = g;
        x.a = a;
        x.d = d;
        x.we = we;
        x.sz = sz;
        x.r0 = g[0] ? RD : 64'h0;
        x.r1 = g[1] ? RD : 64'h0;
        return x;
    endfunction

    // each completed transfer must match the oldest expected one
    always @(negedge clk) begin : monitor
        xfer_t act, exp;
        vectors++;
        if (grant == 2'b11 || (m0_req_ready && !grant[0]) || (m1_req_ready && !grant[1]) || busy != |grant) begin
            miscompares++;
            $display("FAIL invariant: grant=%b busy=%b m0_ready=%b m1_ready=%b", grant, busy, m0_req_ready, m1_req_ready);
        end
        if (bus_req_valid && bus_req_ready) begin
            act.g = grant;
            act.rdy = {m1_req_ready, m0_req_ready};
            act.a = bus_req_addr;
            act.d = bus_req_wdata;
            act.we = bus_req_we;
            act.sz = bus_req_size;
            act.r0 = m0_req_rdata;
            act.r1 = m1_req_rdata;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL xfer: got unexpected %h, expected no transfer", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL xfer: got %h expected %h", act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [63:0] d,
                          input logic we, input logic [2:0] sz, input logic lk);
        m0_req_valid = v;
        m0_req_addr = a;
        m0_req_wdata = d;
        m0_req_we = we;
        m0_req_size = sz;
        m0_req_lock = lk;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [63:0] d,
                          input logic we, input logic [2:0] sz, input logic lk);
        m1_req_valid = v;
        m1_req_addr = a;
        m1_req_wdata = d;
        m1_req_we = we;
        m1_req_size = sz;
        m1_req_lock = lk;
    endtask

    task automatic idle_out(input string name);
        tick;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        tick;
        check(name, busy, 0);
    endtask

    initial begin
        bus_req_ready = 1'b1;
        bus_req_rdata = RD;
        drive0(1, 32'h1000, 64'h1111, 0, 3, 0);
        drive1(1, 32'h2000, 64'h2222, 1, 2, 0);
        #1 reset_n = 1'b0;
        repeat (2) tick;
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst valid", bus_req_valid, 0);
        check("rst addr", bus_req_addr, 0);
        check("rst wdata", bus_req_wdata, 0);
        check("rst we", bus_req_we, 0);
        check("rst size", bus_req_size, 0);
        check("rst m0 ready", m0_req_ready, 0);
        check("rst m1 ready", m1_req_ready, 0);
        check("rst m0 rdata", m0_req_rdata, 0);
        check("rst m1 rdata", m1_req_rdata, 0);
        // strict alternation out of reset
        exp_q.push_back(mk(2'b01, 32'h1000, 64'h1111, 0, 3));
        exp_q.push_back(mk(2'b10, 32'h2000, 64'h2222, 1, 2));
        exp_q.push_back(mk(2'b01, 32'h1000, 64'h1111, 0, 3));
        reset_n = 1'b1;
        tick;
        check("alt c1", grant, 2'b01);
        tick;
        check("alt c2", grant, 2'b10);
        tick;
        check("alt c3", grant, 2'b01);
        m1_req_valid = 1'b0;
        tick;
        check("m0 keeps grant", grant, 2'b01);
        m0_req_valid = 1'b0;
        bus_req_ready = 1'b0;
        #1;
        check("drop valid", bus_req_valid, 0);
        tick;
        check("drop idle busy", busy, 0);
        check("drop idle grant", grant, 0);
        check("drop idle valid", bus_req_valid, 0);
        // single m1 request passes through
        bus_req_ready = 1'b1;
        drive1(1, 32'h8000_0010, 64'hDEAD_BEEF, 1, 2, 0);
        exp_q.push_back(mk(2'b10, 32'h8000_0010, 64'hDEAD_BEEF, 1, 2));
        tick;
        check("m1 grant", grant, 2'b10);
        check("m1 addr", bus_req_addr, 32'h8000_0010);
        check("m1 path m0 ready", m0_req_ready, 0);
        check("m1 path m1 ready", m1_req_ready, 1);
        idle_out("m1 idle");
        // m0 stalled by slave while m1 waits
        bus_req_ready = 1'b0;
        drive0(1, 32'h3000, 64'h3333, 0, 1, 0);
        drive1(1, 32'h4000, 64'h4444, 1, 0, 0);
        exp_q.push_back(mk(2'b01, 32'h3000, 64'h3333, 0, 1));
        exp_q.push_back(mk(2'b10, 32'h4000, 64'h4444, 1, 0));
        for (int k = 1; k <= 3; k++) begin
            tick;
            check("stall grant", grant, 2'b01);
            check("stall m1 ready", m1_req_ready, 0);
        end
        bus_req_ready = 1'b1;
        tick;
        check("after stall", grant, 2'b10);
        m0_req_valid = 1'b0;
        idle_out("stall idle");
        // lock bound: m0 holds 8, m1 gets one, m0 resumes
        drive0(1, 32'h5000, 64'h5555, 1, 3, 1);
        drive1(1, 32'h6000, 64'h6666, 1, 3, 1);
        for (int k = 1; k <= 8; k++) exp_q.push_back(mk(2'b01, 32'h5000 + k * 8, 64'h5555, 1, 3));
        exp_q.push_back(mk(2'b10, 32'h6000, 64'h6666, 1, 3));
        for (int k = 10; k <= 11; k++) exp_q.push_back(mk(2'b01, 32'h5000 + k * 8, 64'h5555, 1, 3));
        for (int k = 1; k <= 11; k++) begin
            tick;
            m0_req_addr = 32'h5000 + k * 8;
            if (k == 8) check("lock c8", grant, 2'b01);
            if (k == 9) begin
                check("lock handoff", grant, 2'b10);
                m1_req_lock = 1'b0;
            end
            if (k == 10) begin
                check("lock resume", grant, 2'b01);
                m1_req_valid = 1'b0;
            end
        end
        idle_out("lock idle");
        // asynchronous reset mid-transfer, then tie goes to m0
        bus_req_ready = 1'b0;
        drive1(1, 32'h7100, 64'h7171, 1, 2, 0);
        tick;
        check("pre-reset grant", grant, 2'b10);
        reset_n = 1'b0;
        #1;
        check("async rst grant", grant, 0);
        check("async rst valid", bus_req_valid, 0);
        check("async rst busy", busy, 0);
        tick;
        reset_n = 1'b1;
        bus_req_ready = 1'b1;
        drive0(1, 32'h7000, 64'h7777, 0, 3, 0);
        exp_q.push_back(mk(2'b01, 32'h7000, 64'h7777, 0, 3));
        tick;
        check("post-rst tie", grant, 2'b01);
        m1_req_valid = 1'b0;
        idle_out("final idle");
        repeat (2) tick;
        check("pending xfers", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bus_master_arbiter.md
BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default `XLEN, address width of all ports.
REQ-002 SHALL have parameter LOCK_MAX, default 8, maximum consecutive locked transfers one master may hold before the grant must pass to a pending other master.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_req_valid/m1_req_valid  in  1  master request valid; m0 is the CPU data port, m1 the secondary master (DMA/debug).
REQ-006 SHALL have ports mX_req_addr  in  XLEN, mX_req_wdata  in  64, mX_req_we  in  1, mX_req_size  in  3 (0=byte..3=double).
REQ-007 SHALL have ports mX_req_lock  in  1  holds the grant across consecutive transfers (atomic sequences).
REQ-008 SHALL have ports mX_req_ready  out  1 and mX_req_rdata  out  64  per-master response.
REQ-009 SHALL have downstream ports bus_req_valid  out  1, bus_req_addr  out  XLEN, bus_req_wdata  out  64, bus_req_we  out  1, bus_req_size  out  3, bus_req_ready  in  1, bus_req_rdata  in  64, matching the system bus master interface.
REQ-010 SHALL have status ports grant  out  2 (one-hot, bit0=m0, bit1=m1) and busy  out  1 (state != IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, GRANT0, GRANT1, held in a register; grant = {state==GRANT1, state==GRANT0}.
REQ-012 SHALL, in IDLE, drive bus_req_valid=0 and all downstream payload outputs 0.
REQ-013 SHALL, in IDLE, select next grant from requesting masters: single requester wins; both requesting -> master other than last_grant wins (round-robin).
REQ-014 SHALL impose exactly one cycle arbitration latency from IDLE: request seen in cycle N -> GRANTx in cycle N+1, bus_req_valid first asserted in N+1.
REQ-015 SHALL, in GRANTx, drive bus_req_* combinationally from master x inputs, mX_req_ready=bus_req_ready, mX_req_rdata=bus_req_rdata; non-granted master ready=0, rdata=0.
REQ-016 SHALL define transfer completion as bus_req_valid && bus_req_ready in a GRANT state; a master's transfer never completes without its own ready pulse.
REQ-017 SHALL hold GRANTx unchanged while bus_req_ready=0 (multi-cycle slaves), regardless of the other master's requests.
REQ-018 SHALL, on completion by master x, update last_grant=x and choose next state: (a) mX_req_lock=1 and lock_cnt+1<LOCK_MAX -> stay GRANTx; (b) else other master valid -> GRANT(other) directly, no IDLE bubble; (c) else mX_req_valid -> stay GRANTx; (d) else IDLE.
REQ-019 SHALL count lock_cnt (width clog2(LOCK_MAX)+1) up on each locked completion that stays granted; reset to 0 on any grant change, on IDLE, or on a completion with lock=0.
REQ-020 SHALL, if the granted master drops mX_req_valid before completion, transition to IDLE next cycle (no transfer issued in that cycle since bus_req_valid follows mX_req_valid).
REQ-021 SHALL ignore lock from a master not currently granted.
REQ-022 SHALL never assert both grant bits, and SHALL never assert mX_req_ready for a non-granted master.
REQ-023 SHALL assert busy=1 in GRANT0/GRANT1, 0 in IDLE.

Reset
REQ-024 SHALL on reset_n=0 immediately (asynchronously) force state=IDLE, last_grant=m1 (so m0 wins first tie), lock_cnt=0.
REQ-025 SHALL hold outputs during reset at: bus_req_valid=0, bus_req_addr/wdata/we/size=0, m0/m1_req_ready=0, rdata=0, grant=2'b00, busy=0.
REQ-026 SHALL, on reset mid-transfer, abandon the transfer; after reset_n rises, arbitration restarts from IDLE per REQ-013/014.

Verification
REQ-027 Out of reset, m0 and m1 both valid in cycle 0, bus_req_ready=1 -> grant=01 cycle 1, 10 cycle 2, 01 cycle 3 (strict alternation, one transfer per cycle).
REQ-028 m1 valid only, addr=0x8000_0010, we=1, wdata=0xDEAD_BEEF, size=2 -> cycle+1 bus_req_* equals m1 inputs; m1_req_ready=1, m0_req_ready=0.
REQ-029 m0 granted, bus_req_ready held 0 for 3 cycles while m1 valid -> grant stays 01 for all 3 cycles; m1_req_ready=0; grant=10 the cycle after completion.
REQ-030 m0 lock=1 issues 10 back-to-back transfers, m1 valid throughout, LOCK_MAX=8 -> m0 completes 8, grant=10 for next transfer, lock_cnt back to 0.
REQ-031 m0 granted, drops valid before ready -> state IDLE next cycle, busy=0, bus_req_valid=0.
REQ-032 reset_n low for 1 cycle while GRANT1 with ready=0 -> grant=00, bus_req_valid=0 asynchronously; after release, both valid -> m0 granted first.
